exec_ctrl: RTL and testbench

Execution controller for the TD4 board top. It turns the raw run switch and step key into a registered one-cycle clock-enable (`cpu_en`) for the mother_board registers. The CPU can be free-run at a fixed instruction period, single-stepped with a debounced key, or stopped by an address breakpoint on the program counter. Everything runs in the single `clk` domain; the CPU advances only on cycles where `cpu_en` is 1.

---
 rtl/exec_ctrl.sv | 130 +++++++++++++
 tb/tb_exec_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execution controller: turns the run switch, step key and PC breakpoint into a
// registered one-cycle CPU clock-enable for the board registers.
module exec_ctrl #(
  parameter int RUN_RATIO       = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       run_sw,
  input  logic       step_n,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] addr,
  output logic       cpu_en,
  output logic       halted,
  output logic [1:0] state,
  output logic [7:0] instr_count
);

  localparam int PER_W = $clog2(RUN_RATIO);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUN_RATIO - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  state_t           st;
  logic             run_p0, run_s;
  logic             step_p0, step_s;
  logic             key_db, key_db_p1;
  logic [DB_W-1:0]  db_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             press;
  logic             bp_hit;

  function automatic logic [PER_W-1:0] next_per(input logic [PER_W-1:0] c);
    return (c == PER_LAST) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [7:0] next_count(input logic [7:0] c);
    return c + 8'd1;
  endfunction

  // Stage 0/1: two-flop synchronisers; the key idles high (released)
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      run_p0  <= 1'b0;
      run_s   <= 1'b0;
      step_p0 <= 1'b1;
      step_s  <= 1'b1;
    end else begin
      run_p0  <= run_sw;
      run_s   <= run_p0;
      step_p0 <= step_n;
      step_s  <= step_p0;
    end
  end

  // Stage 2: debounce; a level is accepted only after it differs for DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_db    <= 1'b1;
      key_db_p1 <= 1'b1;
      db_cnt    <= '0;
    end else begin
      key_db_p1 <= key_db;
      if (step_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= step_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press  = key_db_p1 & ~key_db;
  assign bp_hit = bp_en && (addr == bp_addr);

  // Stage 3: control FSM with registered enable pulse and pulse counter
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      st          <= S_HALT;
      cpu_en      <= 1'b0;
      per_cnt     <= '0;
      instr_count <= 8'd0;
    end else begin
      cpu_en <= 1'b0;
      if (cpu_en) instr_count <= next_count(instr_count);
      case (st)
        S_HALT: begin
          per_cnt <= '0;
          if (run_s)      st     <= S_RUN;
          else if (press) cpu_en <= 1'b1;
        end
        S_RUN: begin
          if (!run_s) begin
            st      <= S_HALT;
            per_cnt <= '0;
          end else begin
            per_cnt <= next_per(per_cnt);
            // The instruction sitting at the breakpoint is held back, not executed
            if (per_cnt == PER_LAST) begin
              if (bp_hit) st     <= S_BREAK;
              else        cpu_en <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          per_cnt <= '0;
          if (!run_s)     st     <= S_HALT;
          else if (press) cpu_en <= 1'b1;
        end
        default: begin
          st      <= S_HALT;
          per_cnt <= '0;
        end
      endcase
    end
  end

  assign state  = st;
  assign halted = (st != S_RUN);

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: stimulus queues expected pulse cycles and
// counts; a negedge monitor pops and compares every cpu_en pulse.
module tb_exec_ctrl;
  localparam int RR = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       run_sw = 1'b0;
  logic       step_n = 1'b1;
  logic       bp_en = 1'b0;
  logic [3:0] bp_addr = 4'd0;
  logic [3:0] addr;
  logic       addr_clr = 1'b1;
  logic       cpu_en, halted;
  logic [1:0] state;
  logic [7:0] instr_count;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];

  exec_ctrl #(.RUN_RATIO(RR), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .n_reset(n_reset), .run_sw(run_sw), .step_n(step_n),
    .bp_en(bp_en), .bp_addr(bp_addr), .addr(addr), .cpu_en(cpu_en),
    .halted(halted), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU model: program counter advances on each enable
  always @(posedge clk) begin
    if (addr_clr)    addr <= 4'd0;
    else if (cpu_en) addr <= addr + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int c);
    exp_t e;
    e.cyc = c;
    e.cnt = exp_cnt;
    sb.push_back(e);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  // Raise run for n pulses, then drop run_sw so run_s falls on the terminal count
  task automatic run_burst(input int n);
    int r;
    r = cyc;
    run_sw = 1'b1;
    for (int i = 0; i < n; i++) expect_pulse(r + 3 + RR + RR * i);
    wait_edge(r + 3);
    check("run_entry_state", state, 1);
    wait_edge(r + 3 + RR * n + 1);
    run_sw = 1'b0;
    wait_edge(r + 3 + RR * n + 4);
    check("stop_state_halt", state, 0);
    check("stop_no_pulse", cpu_en, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_reset && cpu_en) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", instr_count, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    int h, r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_en", cpu_en, 0);
    check("rst_halted", halted, 1);
    check("rst_state", state, 0);
    check("rst_count", instr_count, 0);

    // Reset release with run held: five pulses, then stop on a terminal cycle
    n_reset = 1'b1;
    run_burst(5);
    check("count_after_5", instr_count, 5);

    // Re-enter RUN: first pulse again RR cycles after entry
    wait_edge(cyc + 3);
    run_burst(2);
    check("count_after_7", instr_count, 7);

    // Glitch then stable press in HALT
    wait_edge(cyc + 2);
    step_n = 1'b0;
    wait_edge(cyc + 2);
    step_n = 1'b1;
    wait_edge(cyc + 6);
    h = cyc;
    step_n = 1'b0;
    expect_pulse(h + DB + 3);
    wait_edge(h + 10);
    step_n = 1'b1;
    wait_edge(h + 22);
    check("step_state_halt", state, 0);
    check("step_count", instr_count, exp_cnt);

    // Breakpoint at address 3
    addr_clr = 1'b1;
    wait_edge(cyc + 1);
    addr_clr = 1'b0;
    bp_en = 1'b1;
    bp_addr = 4'd3;
    r = cyc;
    run_sw = 1'b1;
    for (int i = 0; i < 3; i++) expect_pulse(r + 3 + RR + RR * i);
    wait_edge(r + 3 + 4 * RR);
    check("bp_state", state, 2);
    check("bp_halted", halted, 1);
    check("bp_no_pulse", cpu_en, 0);
    check("bp_addr_held", addr, 3);
    h = cyc;
    step_n = 1'b0;
    expect_pulse(h + DB + 3);
    wait_edge(h + DB + 4);
    check("bp_step_addr", addr, 4);
    check("bp_step_state", state, 2);
    step_n = 1'b1;
    wait_edge(h + 20);
    check("bp_stays_break", state, 2);
    run_sw = 1'b0;
    wait_edge(cyc + 3);
    check("bp_exit_halt", state, 0);
    bp_en = 1'b0;

    // Asynchronous reset during a pulse
    wait_edge(cyc + 2);
    r = cyc;
    run_sw = 1'b1;
    wait_edge(r + 3 + RR);
    check("mid_pulse_high", cpu_en, 1);
    n_reset = 1'b0;
    run_sw = 1'b0;
    #1;
    check("arst_cpu_en", cpu_en, 0);
    check("arst_state", state, 0);
    check("arst_halted", halted, 1);
    check("arst_count", instr_count, 0);
    exp_cnt = 8'd0;
    wait_edge(cyc + 2);
    n_reset = 1'b1;
    wait_edge(cyc + 2);

    // 256 pulses wrap the counter back to zero
    run_burst(256);
    check("count_wrap", instr_count, 0);

    wait_edge(cyc + 5);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
